// File: rtl/bin_to_bcd_seq_if.sv
// Bundle of the conversion request/result signals of bin_to_bcd_seq.
//   start    : request a conversion of bin_in (master -> slave)
//   bin_in   : unsigned binary operand, WIDTH bits (master -> slave)
//   busy     : conversion in progress (slave -> master)
//   done     : one-cycle pulse when bcd_out/overflow update (slave -> master)
//   overflow : last captured value did not fit in DIGITS decimal digits
//   bcd_out  : DIGITS packed BCD digits, digit 0 = units in bits [3:0]
//   HEX      : DIGITS active-low 7-segment displays, 7 bits each (a..g)
interface bin_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [7*DIGITS-1:0]   HEX;

    modport master (
        output start, bin_in,
        input  busy, done, overflow, bcd_out, HEX
    );

    modport slave (
        input  start, bin_in,
        output busy, done, overflow, bcd_out, HEX
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle)
// with 7-segment display decode.
//   CLOCK_50 : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : bin_to_bcd_seq_if slave modport (start/bin_in in;
//              busy/done/overflow/bcd_out/HEX out)
// A conversion takes WIDTH SHIFT cycles plus one FINISH cycle; done and the
// new result appear after the FINISH edge.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH    = 9,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    bin_to_bcd_seq_if.slave     bus
);

    // Decimal digits needed for the largest WIDTH-bit value.
    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int unsigned d);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < d; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    localparam int unsigned     SD    = dec_digits(WIDTH);
    localparam int unsigned     SCRW  = 4 * SD;
    localparam int unsigned     BW    = 4 * DIGITS;
    localparam int unsigned     CW    = $clog2(WIDTH + 1);
    localparam longint unsigned LIMIT = pow10(DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [SCRW-1:0]   scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cap_ovf_q, cap_ovf_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic              load_en, shift_en, fin_en;
    logic [SCRW-1:0]   adj;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load_en  = (state_q == IDLE) && bus.start;
        shift_en = (state_q == SHIFT);
        fin_en   = (state_q == FINISH);
        bus.busy = (state_q != IDLE);
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        adj = scr_q;
        for (int unsigned k = 0; k < SD; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
        end

        sh_d      = sh_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        cap_ovf_d = cap_ovf_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = fin_en;

        if (load_en) begin
            sh_d      = bus.bin_in;
            scr_d     = '0;
            cnt_d     = CW'(WIDTH);
            // Range check is done on the captured operand, so the shift
            // register is free to be consumed by the conversion.
            cap_ovf_d = (64'(bus.bin_in) >= LIMIT);
        end else if (shift_en) begin
            // Top scratch bit after adjust is always 0 since the scratch is
            // sized for the full input range; the cast drops it.
            scr_d = SCRW'({adj, sh_q[WIDTH-1]});
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
        end

        if (fin_en) begin
            // Zero-extends or keeps only the low DIGITS digits.
            bcd_d = BW'(scr_q);
            ovf_d = cap_ovf_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sh_q      <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            cap_ovf_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            cap_ovf_q <= cap_ovf_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.bcd_out  = bcd_q;

    // ---------------- Display decode ----------------
    // Walk from the most significant digit down, tracking whether any
    // non-zero digit has been seen, to blank leading zeros.
    logic              seen;
    logic [3:0]        dig;
    logic [6:0]        seg;
    logic [7*DIGITS-1:0] hex;
    int unsigned       kd;

    always_comb begin
        hex  = '1;
        seen = 1'b0;
        dig  = '0;
        seg  = SEG_BLANK;
        kd   = 0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            kd  = DIGITS - 1 - i;
            dig = bcd_q[4*kd +: 4];
            if (dig != 4'd0) seen = 1'b1;
            if (ovf_q)                                     seg = SEG_DASH;
            else if (LZ_BLANK != 0 && kd != 0 && !seen)    seg = SEG_BLANK;
            else                                           seg = seg7(dig);
            hex[7*kd +: 7] = seg;
        end
    end

    assign bus.HEX = hex;

endmodule
